thermo_conv_ctrl: RTL and testbench

- Sequencer for the 7-bit thermometer-to-binary datapath in a flash-ADC front end.
- On a start request, strobes the comparator bank, waits a settle time and captures the 7-bit thermometer code.
- Converts each capture to 0..7, flags bubble (non-thermometer) codes, and accumulates 2^NS_LOG2 samples.
- Returns sum, average and error status over a valid/ready handshake to the downstream consumer.

---
 rtl/thermo_conv_ctrl.sv | 109 ++++++++++
 tb/tb_thermo_conv_ctrl.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/thermo_conv_ctrl.sv
// Flash-ADC thermometer sequencer: strobes the comparator bank, waits for settling,
// decodes 2^NS_LOG2 captures and returns sum/average/bubble status over valid/ready.
module thermo_conv_ctrl #(
  parameter int SETTLE_CYC = 2,
  parameter int NS_LOG2    = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 busy,
  output logic                 sample_en,
  input  logic [6:0]           therm_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [NS_LOG2+2:0]   sum,
  output logic [2:0]           avg,
  output logic                 bubble_err
);

  localparam int             SW          = 3 + NS_LOG2;
  localparam logic [4:0]     SAMP_LAST   = 5'((1 << NS_LOG2) - 1);
  localparam logic [3:0]     SETTLE_LAST = 4'(SETTLE_CYC - 1);

  typedef enum logic [2:0] {IDLE, SAMPLE, SETTLE, CAPTURE, DONE} state_t;

  state_t          state_q, state_d;
  logic [4:0]      samp_cnt_q, samp_cnt_d;
  logic [3:0]      settle_cnt_q, settle_cnt_d;
  logic [SW-1:0]   sum_q, sum_d;
  logic            berr_q, berr_d;

  // Popcount equals the thermometer decode for legal codes and degrades gracefully on bubbles.
  function automatic logic [2:0] popcount7(input logic [6:0] t);
    logic [2:0] c;
    c = '0;
    for (int i = 0; i < 7; i++) c = c + {2'b00, t[i]};
    return c;
  endfunction

  function automatic logic is_therm(input logic [6:0] t);
    logic [6:0] t_inc;
    t_inc = t + 7'd1;
    return (t & t_inc) == 7'd0;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      samp_cnt_q   <= '0;
      settle_cnt_q <= '0;
      sum_q        <= '0;
      berr_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      samp_cnt_q   <= samp_cnt_d;
      settle_cnt_q <= settle_cnt_d;
      sum_q        <= sum_d;
      berr_q       <= berr_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    samp_cnt_d   = samp_cnt_q;
    settle_cnt_d = settle_cnt_q;
    sum_d        = sum_q;
    berr_d       = berr_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = SAMPLE;
          sum_d      = '0;
          berr_d     = 1'b0;
          samp_cnt_d = '0;
        end
      end
      SAMPLE: begin
        state_d      = SETTLE;
        settle_cnt_d = '0;
      end
      SETTLE: begin
        if (settle_cnt_q == SETTLE_LAST) state_d = CAPTURE;
        else settle_cnt_d = settle_cnt_q + 4'd1;
      end
      CAPTURE: begin
        sum_d = sum_q + SW'(popcount7(therm_in));
        if (!is_therm(therm_in)) berr_d = 1'b1;
        if (samp_cnt_q == SAMP_LAST) begin
          state_d = DONE;
        end else begin
          samp_cnt_d = samp_cnt_q + 5'd1;
          state_d    = SAMPLE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy       = (state_q != IDLE);
  assign sample_en  = (state_q == SAMPLE);
  assign out_valid  = (state_q == DONE);
  assign sum        = sum_q;
  assign avg        = sum_q[SW-1:NS_LOG2];
  assign bubble_err = berr_q;

endmodule

// File: tb/tb_thermo_conv_ctrl.sv
// Directed bench for thermo_conv_ctrl: default instance plus two parameter-corner instances.
module tb_thermo_conv_ctrl;

  logic clk = 1'b0;
  logic rst, start, out_ready;
  logic [6:0] therm_in;
  int sel;

  logic start0, start1, start2;
  logic busy0, busy1, busy2, se0, se1, se2, ov0, ov1, ov2, be0, be1, be2;
  logic [4:0] sum0;
  logic [2:0] sum1;
  logic [6:0] sum2;
  logic [2:0] avg0, avg1, avg2;

  logic m_busy, m_se, m_ov, m_be;
  logic [7:0] m_sum;
  logic [2:0] m_avg;

  logic [6:0] codes [16];
  int passed = 0;
  int total = 0;

  always #5 clk = ~clk;

  assign start0 = start && (sel == 0);
  assign start1 = start && (sel == 1);
  assign start2 = start && (sel == 2);

  assign m_busy = (sel == 0) ? busy0 : (sel == 1) ? busy1 : busy2;
  assign m_se   = (sel == 0) ? se0   : (sel == 1) ? se1   : se2;
  assign m_ov   = (sel == 0) ? ov0   : (sel == 1) ? ov1   : ov2;
  assign m_be   = (sel == 0) ? be0   : (sel == 1) ? be1   : be2;
  assign m_sum  = (sel == 0) ? {3'b0, sum0} : (sel == 1) ? {5'b0, sum1} : {1'b0, sum2};
  assign m_avg  = (sel == 0) ? avg0  : (sel == 1) ? avg1  : avg2;

  thermo_conv_ctrl u_def (
    .clk(clk), .rst(rst), .start(start0), .busy(busy0), .sample_en(se0),
    .therm_in(therm_in), .out_valid(ov0), .out_ready(out_ready),
    .sum(sum0), .avg(avg0), .bubble_err(be0)
  );

  thermo_conv_ctrl #(.SETTLE_CYC(1), .NS_LOG2(0)) u_min (
    .clk(clk), .rst(rst), .start(start1), .busy(busy1), .sample_en(se1),
    .therm_in(therm_in), .out_valid(ov1), .out_ready(out_ready),
    .sum(sum1), .avg(avg1), .bubble_err(be1)
  );

  thermo_conv_ctrl #(.SETTLE_CYC(2), .NS_LOG2(4)) u_max (
    .clk(clk), .rst(rst), .start(start2), .busy(busy2), .sample_en(se2),
    .therm_in(therm_in), .out_valid(ov2), .out_ready(out_ready),
    .sum(sum2), .avg(avg2), .bubble_err(be2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input logic [6:0] c);
    for (int i = 0; i < 16; i++) codes[i] = c;
  endtask

  // One conversion on the selected instance; each sample's code is driven when its strobe appears.
  task automatic conv(input int n_samp, input int period, input int lat_exp,
                      input int sum_exp, input int avg_exp, input int berr_exp);
    int n, idx, pulses;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0; idx = 0; pulses = 0;
    while (!m_ov && n < 200) begin
      if (m_se) begin
        chk("sample_phase", 32'(n % period), 0);
        if (idx < 16) therm_in = codes[idx];
        idx++;
        pulses++;
      end
      tick();
      n++;
    end
    chk("latency", 32'(n), 32'(lat_exp));
    chk("pulses", 32'(pulses), 32'(n_samp));
    chk("sum", {24'b0, m_sum}, 32'(sum_exp));
    chk("avg", {29'b0, m_avg}, 32'(avg_exp));
    chk("bubble", {31'b0, m_be}, 32'(berr_exp));
    chk("busy_done", {31'b0, m_busy}, 1);
  endtask

  task automatic handshake(input int sum_exp);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("hs_valid_low", {31'b0, m_ov}, 0);
    chk("hs_idle", {31'b0, m_busy}, 0);
    chk("hs_sum_held", {24'b0, m_sum}, 32'(sum_exp));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; out_ready = 1'b0; therm_in = '0; sel = 0;
    repeat (3) tick();
    chk("rst_outs", {28'b0, busy0, se0, ov0, be0}, 0);
    chk("rst_sum", {24'b0, m_sum}, 0);
    rst = 1'b0;
    repeat (4) begin
      tick();
      chk("idle_quiet", {30'b0, busy0, se0}, 0);
    end

    fill(7'b0011111);
    conv(4, 4, 16, 20, 5, 0);
    handshake(20);

    codes[0] = 7'b0000001; codes[1] = 7'b0000011; codes[2] = 7'b0000111; codes[3] = 7'b1111111;
    conv(4, 4, 16, 13, 3, 0);
    handshake(13);

    fill(7'b0000000);
    conv(4, 4, 16, 0, 0, 0);
    handshake(0);

    fill(7'b0001111);
    codes[1] = 7'b0101111;
    conv(4, 4, 16, 17, 4, 1);
    handshake(17);
    chk("bubble_held_idle", {31'b0, m_be}, 1);
    fill(7'b0001111);
    conv(4, 4, 16, 16, 4, 0);
    handshake(16);

    // Backpressure in DONE with start hammered, then start coincident with out_ready.
    fill(7'b1111111);
    conv(4, 4, 16, 28, 7, 0);
    repeat (5) begin
      start = 1'b1;
      tick();
      chk("bp_valid", {31'b0, m_ov}, 1);
      chk("bp_no_sample", {31'b0, m_se}, 0);
      chk("bp_sum", {24'b0, m_sum}, 28);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("hs_start_ignored", {30'b0, m_busy, m_ov}, 0);
    tick();
    start = 1'b0;
    chk("late_start_sample", {31'b0, m_se}, 1);
    chk("late_start_busy", {31'b0, m_busy}, 1);
    repeat (5) tick();
    chk("partial_sum", {24'b0, m_sum}, 7);

    // Asynchronous reset in the SETTLE phase of the second sample.
    rst = 1'b1;
    #1;
    chk("async_rst_outs", {28'b0, m_busy, m_se, m_ov, m_be}, 0);
    chk("async_rst_sum", {24'b0, m_sum}, 0);
    tick();
    rst = 1'b0;
    repeat (6) begin
      tick();
      chk("post_rst_idle", {29'b0, m_busy, m_se, m_ov}, 0);
    end

    sel = 1;
    fill(7'b1111111);
    conv(1, 3, 3, 7, 7, 0);
    handshake(7);

    sel = 2;
    conv(16, 4, 64, 112, 7, 0);
    handshake(112);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
